// File: rtl/dm_pkg.sv
// Shared access-type encodings, default geometry and address-check helpers for the data-memory stage.
package dm_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam int          DM_DEPTH_LOG2 = 12;
  localparam logic [31:0] DM_BASE_ADDR  = 32'h0000_0000;

  function automatic logic dm_op_legal(input logic [2:0] op);
    return op <= DM_BU;
  endfunction

  function automatic logic dm_aligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      DM_W:        return lo == 2'b00;
      DM_H, DM_HU: return !lo[0];
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_unit_if.sv
// Datapath-to-data-memory bus: address/store data/control in, extended load data and fault out.
interface dm_unit_if;
  logic [31:0] PC;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        MemWrite;
  logic [2:0]  DMOp;
  logic [31:0] RD;
  logic        AdErr;

  modport master (output PC, Addr, WD, MemWrite, DMOp, input RD, AdErr);
  modport slave  (input PC, Addr, WD, MemWrite, DMOp, output RD, AdErr);
endinterface

// File: rtl/dm_load_ext.sv
// Load lane select and zero/sign extension; purely combinational, 0-cycle latency.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half = lane[1] ? word[31:16] : word[15:0];
    byt  = word[7:0];
    case (lane)
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      2'd3:    byt = word[31:24];
      default: byt = word[7:0];
    endcase
    case (op)
      DM_W:    data = word;
      DM_H:    data = {{16{half[15]}}, half};
      DM_HU:   data = {16'h0000, half};
      DM_B:    data = {{24{byt[7]}}, byt};
      DM_BU:   data = {24'h000000, byt};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// Single-cycle data memory: combinational extended loads, lane-merged stores on the rising edge.
// Define DM_WRITE_LOG_EN to print "@PC: *addr <= word" for every committed store.
module dm_unit
  import dm_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DM_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DM_BASE_ADDR
)
(
  input  logic       clk,
  input  logic       reset,
  dm_unit_if.slave   bus
);

  localparam int          WORDS = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'(WORDS) << 2;

  logic [31:0]           mem [WORDS];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  aderr;
  logic                  we;
  logic [31:0]           rword;
  logic [31:0]           ext;
  logic [31:0]           wlane;
  logic [31:0]           merged;
  logic [3:0]            be;

  // Unsigned compare of the offset rejects addresses below the base as well as past the top.
  assign off   = bus.Addr - BASE_ADDR;
  assign idx   = off[DEPTH_LOG2+1:2];
  assign aderr = !((off < SPAN) && dm_op_legal(bus.DMOp) && dm_aligned(bus.DMOp, bus.Addr[1:0]));
  assign we    = bus.MemWrite && !aderr;
  assign rword = mem[idx];

  dm_load_ext u_load_ext (
    .word (rword),
    .lane (bus.Addr[1:0]),
    .op   (bus.DMOp),
    .data (ext)
  );

  assign bus.RD    = aderr ? 32'h0000_0000 : ext;
  assign bus.AdErr = aderr;

  always_comb begin
    be     = 4'b0000;
    wlane  = bus.WD;
    merged = rword;
    case (bus.DMOp)
      DM_W: be = 4'b1111;
      DM_H, DM_HU: begin
        be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.WD[15:0]}};
      end
      DM_B, DM_BU: begin
        be    = 4'b0001 << bus.Addr[1:0];
        wlane = {4{bus.WD[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wlane[8*k +: 8];
    end
  end

  // Reset clears the whole array asynchronously so loads read zero immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0000_0000;
    end else if (we) begin
      mem[idx] <= merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (reset && we) $display("@%h: *%h <= %h", bus.PC, {bus.Addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.PC;
`endif

endmodule

// File: tb/tb_dm_unit.sv
// Directed plus random bench for dm_unit against a byte-addressed reference memory.
module tb_dm_unit;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned SPAN_B = 4 * 4096;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc_cnt = 32'h0040_0000;
  logic [7:0]  refm [int unsigned];

  dm_unit_if bus ();

  dm_unit #(.DEPTH_LOG2(12), .BASE_ADDR(BASE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] getb(input int unsigned a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] o;
    o = a - BASE;
    if (op > 3'd4) return 1'b1;
    if (o >= SPAN_B) return 1'b1;
    if (op == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [2:0] op);
    int unsigned o, v;
    if (ref_err(a, op)) return 32'h0;
    o = a - BASE;
    v = 0;
    case (op)
      3'd0: v = getb(o) + getb(o+1) * 256 + getb(o+2) * 65536 + getb(o+3) * 16777216;
      3'd1, 3'd2: begin
        v = getb(o) + getb(o+1) * 256;
        if (op == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: begin
        v = getb(o);
        if (op == 3'd3 && v >= 128) v = v + 32'hFFFF_FF00;
      end
    endcase
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
    int unsigned o, n;
    o = a - BASE;
    n = (op == 3'd0) ? 4 : (op <= 3'd2) ? 2 : 1;
    for (int k = 0; k < n; k++) refm[o + k] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  task automatic chk(input string tag, input logic [31:0] got_rd, input logic [31:0] exp_rd,
                     input logic got_e, input logic exp_e);
    checks++;
    assert (got_rd === exp_rd) else begin
      errors++;
      $error("FAIL %s RD: got %h expected %h", tag, got_rd, exp_rd);
    end
    checks++;
    assert (got_e === exp_e) else begin
      errors++;
      $error("FAIL %s AdErr: got %b expected %b", tag, got_e, exp_e);
    end
  endtask

  // One access: drive at negedge, check pre-edge outputs against the model, then let the edge commit.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [2:0] op);
    logic ee;
    @(negedge clk);
    bus.PC = pc_cnt; bus.Addr = a; bus.WD = wd; bus.MemWrite = we; bus.DMOp = op;
    pc_cnt = pc_cnt + 4;
    #1;
    ee = ref_err(a, op);
    chk(tag, bus.RD, ref_rd(a, op), bus.AdErr, ee);
    @(posedge clk);
    if (we && !ee && reset) ref_write(a, wd, op);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [31:0] a, input logic [2:0] op,
                          input logic [31:0] exp_rd, input logic exp_e);
    do_op(tag, a, 32'h0, 1'b0, op);
    chk({tag, "_k"}, bus.RD, exp_rd, bus.AdErr, exp_e);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  op;
    logic        we;
    int unsigned r;

    bus.PC = 32'h0; bus.Addr = 32'h0; bus.WD = 32'h0; bus.MemWrite = 1'b0; bus.DMOp = 3'd0;
    #1 reset = 1'b0;
    refm.delete();
    rd_const("rst_hold", 32'h0000_0010, 3'd0, 32'h0, 1'b0);
    @(negedge clk); #2 reset = 1'b1;
    rd_const("rst_0", 32'h0000_0000, 3'd0, 32'h0, 1'b0);
    rd_const("rst_3ffc", 32'h0000_3FFC, 3'd0, 32'h0, 1'b0);
    rd_const("rst_1234", 32'h0000_1234, 3'd0, 32'h0, 1'b0);

    do_op("sw10", 32'h10, 32'h8765_4321, 1'b1, 3'd0);
    rd_const("lw10", 32'h10, 3'd0, 32'h8765_4321, 1'b0);
    rd_const("lb13", 32'h13, 3'd3, 32'hFFFF_FF87, 1'b0);
    rd_const("lbu13", 32'h13, 3'd4, 32'h0000_0087, 1'b0);
    rd_const("lh12", 32'h12, 3'd1, 32'hFFFF_8765, 1'b0);
    rd_const("lhu10", 32'h10, 3'd2, 32'h0000_4321, 1'b0);
    do_op("sb11", 32'h11, 32'hAABB_CCDD, 1'b1, 3'd3);
    do_op("sh12", 32'h12, 32'h1111_2222, 1'b1, 3'd1);
    rd_const("merge", 32'h10, 3'd0, 32'h2222_DD21, 1'b0);

    do_op("sw22_mis", 32'h22, 32'h0000_0FFF, 1'b1, 3'd0);
    rd_const("sw22_mis_k", 32'h22, 3'd0, 32'h0, 1'b1);
    rd_const("lw20_unch", 32'h20, 3'd0, 32'h0, 1'b0);
    rd_const("lw4000", 32'h0000_4000, 3'd0, 32'h0, 1'b1);
    rd_const("op101", 32'h10, 3'd5, 32'h0, 1'b1);
    rd_const("lhu_mis", 32'h11, 3'd2, 32'h0, 1'b1);
    do_op("sw3ffc", 32'h3FFC, 32'h5A5A_A5A5, 1'b1, 3'd0);
    rd_const("lb3fff", 32'h3FFF, 3'd3, 32'h0000_005A, 1'b0);
    rd_const("lb4000", 32'h4000, 3'd3, 32'h0, 1'b1);
    rd_const("lw0_nowrap", 32'h0, 3'd0, 32'h0, 1'b0);

    // Read-during-write shows old data, new data after the edge.
    do_op("rdw", 32'h10, 32'h0BAD_F00D, 1'b1, 3'd0);
    rd_const("rdw_after", 32'h10, 3'd0, 32'h0BAD_F00D, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 15);
      wd = $urandom();
      we = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 4));
      if (r == 0) a = $urandom();
      else if (r == 1) a = 32'h3FF0 + 32'($urandom_range(0, 31));
      else a = 32'($urandom_range(0, 63));
      if (r == 2) op = 3'($urandom_range(5, 7));
      do_op("rnd", a, wd, we, op);
    end

    @(negedge clk);
    bus.MemWrite = 1'b0; bus.Addr = 'x; bus.DMOp = 'x; bus.WD = 'x;
    @(posedge clk); #1;
    for (int w = 0; w < 16; w++) do_op("sweep", 32'(w * 4), 32'h0, 1'b0, 3'd0);
    for (int w = 0; w < 4; w++) do_op("sweep_top", 32'h3FF0 + 32'(w * 4), 32'h0, 1'b0, 3'd0);

    do_op("mr_sw", 32'h10, 32'hCAFE_F00D, 1'b1, 3'd0);
    @(negedge clk);
    bus.Addr = 32'h10; bus.DMOp = 3'd0; bus.MemWrite = 1'b0;
    #1 chk("mr_pre", bus.RD, 32'hCAFE_F00D, bus.AdErr, 1'b0);
    #1 reset = 1'b0;
    refm.delete();
    #1 chk("mr_clr", bus.RD, 32'h0, bus.AdErr, 1'b0);
    do_op("rst_sw", 32'h20, 32'h1234_5678, 1'b1, 3'd0);
    rd_const("rst_mis", 32'h22, 3'd0, 32'h0, 1'b1);
    @(negedge clk); #2 reset = 1'b1;
    rd_const("rst_sw_ign", 32'h20, 3'd0, 32'h0, 1'b0);
    rd_const("rst_lw10", 32'h10, 3'd0, 32'h0, 1'b0);
    do_op("post_sw", 32'h20, 32'h1234_5678, 1'b1, 3'd0);
    rd_const("post_lw", 32'h20, 3'd0, 32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
